// File: rtl/fir_resampler_out_buffer.sv
// fir_resampler_out_buffer
//   Downstream stage of the FIR resampler. Issues credit-limited, rate-limited
//   one-cycle data requests to the resampler, captures the returned words into a
//   show-ahead FIFO and hands them to a consumer over valid/ready. Resampler error
//   flags and protocol faults are kept as sticky status for the control plane.
//
//   Optional build macro: FIR_RESAMPLER_OBUF_TIMEOUT_EN
//     Defined     - in-flight timeout counter; after TIMEOUT cycles without data
//                   while requests are outstanding, the credit count is dropped to
//                   zero and timeout_o is set.
//     Not defined - timeout_o is tied low and TIMEOUT is unused.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            run request (level)
//   clr_i               synchronous clear of all sticky status bits
//   rs_data_req_o       one-cycle request pulse to the resampler
//   rs_data_i/_val_i    returned resampler word and its strobe
//   rs_err_flg_i        resampler error flags
//   data_o/data_val_o   head-of-FIFO word / FIFO non-empty
//   data_rdy_i          consumer ready; pop on data_val_o && data_rdy_i
//   level_o             words stored
//   busy_o              block not idle
//   err_flg_o           sticky OR of rs_err_flg_i
//   overflow_o          sticky: word dropped on a full FIFO
//   unsolicited_o       sticky: data returned with no request outstanding
//   timeout_o           sticky: in-flight timeout (optional feature)
module fir_resampler_out_buffer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned REQ_GAP      = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clr_i,
    output logic                    rs_data_req_o,
    input  logic [DATA_WIDTH-1:0]   rs_data_i,
    input  logic                    rs_data_val_i,
    input  logic [4:0]              rs_err_flg_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    data_val_o,
    input  logic                    data_rdy_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    busy_o,
    output logic [4:0]              err_flg_o,
    output logic                    overflow_o,
    output logic                    unsolicited_o,
    output logic                    timeout_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned GW = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [LW-1:0]           level_q, level_d;
    logic [LW-1:0]           inflight_q, inflight_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    req_q, req_cond;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   head_q, head_d;
    logic                    val_q, val_d;
    logic [LW:0]             occupancy;
    logic                    full, push, pop, ret_ok;
    logic [4:0]              err_q, err_d;
    logic                    ovf_q, ovf_d, unsol_q, unsol_d;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StRun;
            StRun:   if (!enable_i) state_d = StDrain;
            StDrain: begin
                if (enable_i) begin
                    state_d = StRun;
                end else if (inflight_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- request / credit
    // Stored words plus outstanding requests must never exceed the FIFO, so every
    // requested word is guaranteed a slot when it returns.
    assign occupancy = {1'b0, level_q} + {1'b0, inflight_q};
    assign req_cond  = (state_q == StRun) && (gap_q == '0) &&
                       (inflight_q < LW'(MAX_INFLIGHT)) && (occupancy < (LW+1)'(DEPTH));

    assign full   = (level_q == LW'(DEPTH));
    assign push   = rs_data_val_i && !full;
    assign pop    = val_q && data_rdy_i;
    assign ret_ok = rs_data_val_i && (inflight_q != '0);

    always_comb begin
        gap_d = gap_q;
        if (req_cond) begin
            gap_d = GW'(REQ_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

`ifdef FIR_RESAMPLER_OBUF_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_hit;
    logic          tmo_q, tmo_d;

    // Counts cycles spent waiting with credits outstanding; any returned word restarts it.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (rs_data_val_i || (inflight_q == '0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            tmo_cnt_d   = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    assign tmo_d = clr_i ? 1'b0 : (tmo_q | timeout_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        inflight_d = inflight_q;
        if (req_cond && !ret_ok) begin
            inflight_d = inflight_q + LW'(1);
        end else if (!req_cond && ret_ok) begin
            inflight_d = inflight_q - LW'(1);
        end
`ifdef FIR_RESAMPLER_OBUF_TIMEOUT_EN
        // Lost credits are written off; a request issued on the same edge still counts.
        if (timeout_hit) begin
            inflight_d = req_cond ? LW'(1) : '0;
        end
`endif
    end

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Head register: a push into a FIFO that is (or is about to become) empty
    // bypasses the array, since that slot is only written on this same edge.
    always_comb begin
        head_d = head_q;
        if (push && ((level_q == '0) || ((level_q == LW'(1)) && pop))) begin
            head_d = rs_data_i;
        end else if (pop) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    assign val_d = (level_d != '0);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rs_data_i;
    end

    // ---------------------------------------------------------------- sticky status
    // A clear in the same cycle as an event wins.
    assign err_d   = clr_i ? 5'b0 : (err_q | rs_err_flg_i);
    assign ovf_d   = clr_i ? 1'b0 : (ovf_q | (rs_data_val_i && full));
    assign unsol_d = clr_i ? 1'b0 : (unsol_q | (rs_data_val_i && (inflight_q == '0)));

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            level_q    <= '0;
            inflight_q <= '0;
            gap_q      <= '0;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            val_q      <= 1'b0;
            err_q      <= '0;
            ovf_q      <= 1'b0;
            unsol_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            gap_q      <= gap_d;
            req_q      <= req_cond;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            val_q      <= val_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            unsol_q    <= unsol_d;
        end
    end

    assign rs_data_req_o = req_q;
    assign data_o        = head_q;
    assign data_val_o    = val_q;
    assign level_o       = level_q;
    assign busy_o        = (state_q != StIdle);
    assign err_flg_o     = err_q;
    assign overflow_o    = ovf_q;
    assign unsolicited_o = unsol_q;

endmodule

// File: tb/tb_fir_resampler_out_buffer.sv
// Self-checking bench for fir_resampler_out_buffer (DEPTH=8, MAX_INFLIGHT=2, REQ_GAP=4).
// A behavioural model (word queue, credit count, sticky flags, request rules) is
// advanced on every clock edge and compared with the DUT one time unit later.
module tb_fir_resampler_out_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int MAXI  = 2;
    localparam int GAP   = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i, clr_i, rs_data_req_o, rs_data_val_i, data_val_o, data_rdy_i;
    logic [DW-1:0] rs_data_i, data_o;
    logic [4:0]    rs_err_flg_i, err_flg_o;
    logic [3:0]    level_o;
    logic          busy_o, overflow_o, unsolicited_o, timeout_o;

    always #5 clk = ~clk;

    fir_resampler_out_buffer #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAXI),
        .REQ_GAP      (GAP),
        .TIMEOUT      (64)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .clr_i         (clr_i),
        .rs_data_req_o (rs_data_req_o),
        .rs_data_i     (rs_data_i),
        .rs_data_val_i (rs_data_val_i),
        .rs_err_flg_i  (rs_err_flg_i),
        .data_o        (data_o),
        .data_val_o    (data_val_o),
        .data_rdy_i    (data_rdy_i),
        .level_o       (level_o),
        .busy_o        (busy_o),
        .err_flg_o     (err_flg_o),
        .overflow_o    (overflow_o),
        .unsolicited_o (unsolicited_o),
        .timeout_o     (timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Stimulus controls
    logic          en, clr, rdy, man_val;
    logic [DW-1:0] man_data;
    logic [4:0]    err_in;
    bit            auto_resp, rand_dly, strict_gap, lvl_le1, first_pending, prev_req_in_phase;
    int            resp_dly, en_cyc;

    // Reference model
    logic [DW-1:0] mq[$];
    int            ret_q[$];
    int            m_infl, last_req, last_ret, n_req;
    logic [4:0]    m_err;
    bit            m_ovf, m_unsol, en_h0, en_h1;

    typedef struct {
        logic [4:0] err;
        logic       clr;
        logic [4:0] exp_err;
        logic       exp_unsol;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ret_q.delete();
        m_infl = 0; m_err = '0; m_ovf = 0; m_unsol = 0;
        en_h0 = 0; en_h1 = 0;
        last_req = cyc - 100; last_ret = cyc; prev_req_in_phase = 0;
    endtask

    task automatic cycle();
        logic          v;
        logic [DW-1:0] d;
        bit            full, ovf_ev, unsol_ev;
        int            r;
        v = man_val; d = man_data; ovf_ev = 0; unsol_ev = 0;
        if (auto_resp && ret_q.size() > 0 && ret_q[0] <= cyc) begin
            v = 1'b1; d = DW'($urandom); ret_q.delete(0);
        end
        enable_i = en; clr_i = clr; data_rdy_i = rdy;
        rs_data_val_i = v; rs_data_i = d; rs_err_flg_i = err_in;
        @(posedge clk);
        cyc++;
        full = (mq.size() == DEPTH);
        if (mq.size() > 0 && rdy) mq.delete(0);
        if (v) begin
            if (!full) mq.push_back(d);
            else ovf_ev = 1;
            if (m_infl > 0) m_infl--;
            else unsol_ev = 1;
        end
        if (clr) begin
            m_err = '0; m_ovf = 0; m_unsol = 0;
        end else begin
            m_err |= err_in; m_ovf |= ovf_ev; m_unsol |= unsol_ev;
        end
        en_h1 = en_h0; en_h0 = en;
        #1;
        if (rs_data_req_o) begin
            n_req++;
            m_infl++;
            chk("req_only_when_running", en_h1, 1);
            chk("req_min_gap", (cyc - last_req >= GAP), 1);
            if (strict_gap && prev_req_in_phase) chk("req_spacing", cyc - last_req, GAP);
            chk("req_credit_limit", (m_infl <= MAXI), 1);
            chk("req_fifo_room", (mq.size() + m_infl <= DEPTH), 1);
            if (first_pending) begin
                chk("first_req_latency", cyc - en_cyc, 2);
                first_pending = 0;
            end
            last_req = cyc; prev_req_in_phase = 1;
            if (auto_resp) begin
                r = cyc + (rand_dly ? int'($urandom_range(1, 8)) : resp_dly);
                if (r <= last_ret) r = last_ret + 1;
                ret_q.push_back(r);
                last_ret = r;
            end
        end
        chk("level", level_o, mq.size());
        chk("data_val", data_val_o, (mq.size() != 0));
        if (mq.size() != 0) chk("data_head", data_o, mq[0]);
        chk("err_flg", err_flg_o, m_err);
        chk("overflow", overflow_o, m_ovf);
        chk("unsolicited", unsolicited_o, m_unsol);
        chk("timeout", timeout_o, 0);
        if (lvl_le1) chk("level_le1", (level_o <= 1), 1);
    endtask

    task automatic settle_idle();
        en = 0; rdy = 1; err_in = '0; clr = 0; man_val = 0;
        for (int i = 0; i < 100 && (m_infl > 0 || ret_q.size() > 0 || mq.size() > 0); i++) cycle();
        chk("settle_idle", (m_infl == 0 && mq.size() == 0), 1);
        cycle(); cycle();
    endtask

    initial begin
        int nr, n0;
        bit got;
        tbl[0] = '{5'b00000, 1'b1, 5'b00000, 1'b0};
        tbl[1] = '{5'b00100, 1'b0, 5'b00100, 1'b0};
        tbl[2] = '{5'b00001, 1'b0, 5'b00101, 1'b0};
        tbl[3] = '{5'b00000, 1'b0, 5'b00101, 1'b0};
        tbl[4] = '{5'b00010, 1'b1, 5'b00000, 1'b0};
        tbl[5] = '{5'b00000, 1'b0, 5'b00000, 1'b0};

        en = 0; clr = 0; rdy = 0; man_val = 0; man_data = '0; err_in = '0;
        auto_resp = 0; rand_dly = 0; strict_gap = 0; lvl_le1 = 0; first_pending = 0;
        resp_dly = 3; n_req = 0;
        enable_i = 0; clr_i = 0; data_rdy_i = 0; rs_data_val_i = 0; rs_data_i = '0;
        rs_err_flg_i = '0;
        rst_i = 1'b1;
        #1;
        chk("reset_req", rs_data_req_o, 0);
        chk("reset_val", data_val_o, 0);
        chk("reset_level", level_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_err", err_flg_o, 0);
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        model_reset();

        // 1: steady stream, data returned 3 cycles after each request
        en = 1; rdy = 1; auto_resp = 1; resp_dly = 3; strict_gap = 1; lvl_le1 = 1;
        en_cyc = cyc; first_pending = 1; n0 = n_req;
        for (int i = 0; i < 60; i++) cycle();
        chk("t1_req_count", (n_req - n0 >= 13), 1);
        strict_gap = 0; lvl_le1 = 0;

        // 2: consumer stalled, FIFO fills to DEPTH without overflow
        rdy = 0;
        for (int i = 0; i < 45; i++) cycle();
        nr = n_req;
        for (int i = 0; i < 15; i++) cycle();
        chk("t2_req_stopped", n_req - nr, 0);
        chk("t2_level_full", level_o, 8);
        chk("t2_no_overflow", overflow_o, 0);
        // word arriving on a full FIFO is dropped and flagged
        en = 0;
        for (int i = 0; i < 4; i++) cycle();
        man_val = 1; man_data = 16'hA5A5;
        cycle();
        man_val = 0;
        chk("t2_overflow_set", overflow_o, 1);
        chk("t2_level_held", level_o, 8);
        clr = 1; cycle(); clr = 0;
        chk("t2_overflow_clr", overflow_o, 0);
        en = 1; rdy = 1; nr = n_req;
        for (int i = 0; i < 60; i++) cycle();
        chk("t2_req_resumed", (n_req > nr), 1);

        // 3 + 5: unsolicited word, then sticky error table
        settle_idle();
        rdy = 0; man_val = 1; man_data = 16'hBEEF;
        cycle();
        man_val = 0;
        chk("t3_unsol_word", data_o, 16'hBEEF);
        chk("t3_unsol_flag", unsolicited_o, 1);
        for (int i = 0; i < 6; i++) begin
            err_in = tbl[i].err; clr = tbl[i].clr;
            cycle();
            chk($sformatf("t5_err_row%0d", i), err_flg_o, tbl[i].exp_err);
            chk($sformatf("t5_unsol_row%0d", i), unsolicited_o, tbl[i].exp_unsol);
        end
        err_in = '0; clr = 0;
        settle_idle();

        // 4: disable with two requests outstanding
        en = 1; rdy = 1; resp_dly = 10;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            got = (m_infl == 2);
        end
        chk("t4_reach_inflight2", got, 1);
        en = 0;
        cycle();
        nr = n_req;
        for (int i = 0; i < 40 && m_infl > 0; i++) begin
            cycle();
            if (m_infl > 0) chk("t4_busy_drain", busy_o, 1);
        end
        chk("t4_drained", m_infl, 0);
        chk("t4_busy_tail", busy_o, 1);
        cycle();
        chk("t4_busy_idle", busy_o, 0);
        chk("t4_no_req_in_drain", n_req - nr, 0);

        // randomized traffic
        settle_idle();
        rand_dly = 1; en = 1;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            err_in = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'b0;
            clr = ($urandom_range(0, 24) == 0);
            cycle();
        end
        rand_dly = 0; resp_dly = 3;
        settle_idle();

        // 6: asynchronous reset mid-stream
        en = 1; rdy = 0; err_in = 5'b10000;
        for (int i = 0; i < 20; i++) cycle();
        chk("t6_prereset_level", (level_o != 0), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_req", rs_data_req_o, 0);
        chk("t6_rst_data", data_o, 0);
        chk("t6_rst_val", data_val_o, 0);
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_err", err_flg_o, 0);
        chk("t6_rst_ovf", overflow_o, 0);
        chk("t6_rst_unsol", unsolicited_o, 0);
        chk("t6_rst_tmo", timeout_o, 0);
        en = 0; err_in = '0; rdy = 1;
        enable_i = 0; rs_err_flg_i = '0; rs_data_val_i = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        nr = n_req;
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_no_req_disabled", n_req - nr, 0);
        en = 1; en_cyc = cyc; first_pending = 1;
        for (int i = 0; i < 10 && first_pending; i++) cycle();
        chk("t6_first_req_seen", first_pending, 0);
        settle_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_resampler_out_buffer.md
Name: fir_resampler_out_buffer

Overview:
Downstream stage of the FIR resampler. Generates the resampler's data request pulses on a credit basis and captures the resampled words into a show-ahead FIFO. Hands the words to a consumer over a valid/ready handshake. Also latches resampler error flags and protocol faults as sticky status for the control plane.

Parameters:
DATA_WIDTH, 16, width of resampled words (matches resampler OUT_WIDTH)
DEPTH, 16, FIFO depth in words; power of two, >= 4
MAX_INFLIGHT, 4, max outstanding requests without returned data; 1..DEPTH
REQ_GAP, 4, min clock cycles between request pulses; >= 1
TIMEOUT, 1024, cycles without data before an in-flight timeout (used only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
enable_i  in  1  run request; level-sensitive
clr_i  in  1  synchronous clear of sticky status bits
rs_data_req_o  out  1  one-cycle request pulse to resampler data_req_i
rs_data_i  in  DATA_WIDTH  resampler data_o
rs_data_val_i  in  1  resampler data_val_o
rs_err_flg_i  in  5  resampler err_flg_o
data_o  out  DATA_WIDTH  head-of-FIFO word
data_val_o  out  1  FIFO non-empty
data_rdy_i  in  1  consumer ready; pop when data_val_o && data_rdy_i
level_o  out  $clog2(DEPTH)+1  words stored
busy_o  out  1  state != IDLE
err_flg_o  out  5  sticky OR of rs_err_flg_i
overflow_o  out  1  sticky: word dropped because FIFO was full
unsolicited_o  out  1  sticky: rs_data_val_i arrived with inflight == 0
timeout_o  out  1  sticky: in-flight timeout (optional feature)

Behaviour:
- Reset (asynchronous, no clock needed): all outputs 0, FIFO empty, inflight = 0, gap counter = 0, state = IDLE.
- States:
  - IDLE -> RUN when enable_i = 1.
  - RUN -> DRAIN when enable_i = 0.
  - DRAIN -> IDLE when inflight = 0.
  - DRAIN -> RUN when enable_i returns to 1.
- Request condition, evaluated each cycle: state = RUN, gap = 0, inflight < MAX_INFLIGHT, and level + inflight < DEPTH.
  - rs_data_req_o is registered: it goes high for exactly one cycle, on the clock edge after the condition is true.
  - The same edge increments inflight and loads gap with REQ_GAP-1. Gap then decrements to 0.
- Capture: rs_data_val_i = 1 pushes rs_data_i when the FIFO is not full at the start of the cycle.
  - If full, the word is dropped and overflow_o is set.
  - If inflight > 0, it decrements. If inflight = 0, unsolicited_o is set and the word is still stored if space allows.
  - If a request edge and a data return occur in the same cycle, inflight is unchanged.
- FIFO: show-ahead; data_o and data_val_o are valid from registers.
  - A pushed word is visible on data_o one cycle after the rs_data_val_i cycle.
  - Push and pop in the same cycle: level unchanged. Pointers wrap modulo DEPTH.
  - Pop on an empty FIFO is impossible, because data_val_o gates the pop.
- Ordering: words leave in arrival order, never duplicated.
- Sticky bits:
  - err_flg_o |= rs_err_flg_i every cycle.
  - clr_i zeroes err_flg_o, overflow_o, unsolicited_o and timeout_o. Same-cycle events are lost to the clear (clear wins).
- DRAIN: no new requests; returning words are still captured and output.
- enable_i toggling never flushes the FIFO; only rst_i does.

Optional Feature:
FIR_RESAMPLER_OBUF_TIMEOUT_EN
- Defined:
  - A counter runs while inflight > 0 and resets on every rs_data_val_i.
  - When it reaches TIMEOUT: inflight is forced to 0, timeout_o is set, and the block releases DRAIN.
- Not defined: timeout_o is tied to 0, no counter logic is built, and TIMEOUT is ignored.

Test Plan:
1. Config DEPTH=8, MAX_INFLIGHT=2, REQ_GAP=4. Enable; model returns data 3 cycles after each request; data_rdy_i=1 -> request pulses every 4 cycles, data_o sequence matches model order, level_o <= 1, no sticky bits set.
2. data_rdy_i=0 -> requests stop once level+inflight=8, level_o reaches 8, overflow_o=0. Raise data_rdy_i -> 8 words drain in order and requests resume.
3. Pulse rs_data_val_i with inflight=0 -> unsolicited_o=1 and the word appears on data_o. Pulse clr_i -> unsolicited_o=0.
4. Deassert enable_i with inflight=2 -> no further rs_data_req_o, busy_o=1 until both words return, then IDLE with busy_o=0.
5. rs_err_flg_i=5'b00100 for one cycle, then 5'b00001 -> err_flg_o=5'b00101 held. clr_i -> 5'b00000.
6. Assert rst_i mid-stream between clock edges -> all outputs 0 immediately. After release, the first request occurs only after enable_i is seen.
